// File: rtl/rv_alu_arbiter_if.sv
// Bundle of every non-clock signal of rv_alu_arbiter: the requester side,
// the ALU side and the response port, plus a small debug view of the
// response state and the round-robin pointer.
interface rv_alu_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_REQ    = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Requester side (packed: requester k at [k*W +: W])
    logic                           flush_i;
    logic [NUM_REQ-1:0]             req_valid_i;
    logic [NUM_REQ-1:0]             req_ready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_opr_a_i;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_opr_b_i;
    logic [NUM_REQ*5-1:0]           req_op_sel_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_pc_i;

    // ALU side
    logic [DATA_WIDTH-1:0]          alu_opr_a_o;
    logic [DATA_WIDTH-1:0]          alu_opr_b_o;
    logic [4:0]                     alu_op_sel_o;
    logic [ADDR_WIDTH-1:0]          alu_pc_o;
    logic [DATA_WIDTH-1:0]          alu_res_i;
    logic                           alu_zero_i;

    // Response port
    logic                           rsp_valid_o;
    logic                           rsp_ready_i;
    logic [ID_W-1:0]                rsp_id_o;
    logic [DATA_WIDTH-1:0]          rsp_res_o;
    logic                           rsp_zero_o;

    // Debug view: response register state (1 = FULL) and priority pointer
    logic                           dbg_rsp_full_o;
    logic [ID_W-1:0]                dbg_ptr_o;

    // Arbiter view
    modport slave (
        input  flush_i, req_valid_i, req_opr_a_i, req_opr_b_i, req_op_sel_i, req_pc_i,
        input  alu_res_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_opr_a_o, alu_opr_b_o, alu_op_sel_o, alu_pc_o,
        output rsp_valid_o, rsp_id_o, rsp_res_o, rsp_zero_o,
        output dbg_rsp_full_o, dbg_ptr_o
    );

    // Core / ALU / consumer view
    modport master (
        output flush_i, req_valid_i, req_opr_a_i, req_opr_b_i, req_op_sel_i, req_pc_i,
        output alu_res_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_opr_a_o, alu_opr_b_o, alu_op_sel_o, alu_pc_o,
        input  rsp_valid_o, rsp_id_o, rsp_res_o, rsp_zero_o,
        input  dbg_rsp_full_o, dbg_ptr_o
    );
endinterface

// File: rtl/rv_alu_arbiter.sv
// rv_alu_arbiter: round-robin sharing of one combinational rv_alu between
// NUM_REQ requesters. The winner's operands drive the ALU; the ALU result is
// captured in a single-entry response register tagged with the winner's ID.
//
// Handshake semantics (all ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. A requester keeps valid high with a
// stable payload until it sees ready; ready may depend combinationally on
// valid. The response register presents rsp_valid_o and holds its data until
// rsp_ready_i is seen high at an edge; flush_i discards it instead.
module rv_alu_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_REQ    = 2
) (
    input  logic               clk,
    input  logic               reset,
    rv_alu_arbiter_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic                  rsp_zero_q, rsp_zero_d;

    logic                  have_winner;
    logic [ID_W-1:0]       winner;
    logic                  can_accept;
    logic                  accept;

    // Round-robin search starting at ptr_q, wrapping at NUM_REQ-1.
    always_comb begin
        logic [ID_W-1:0] idx;
        have_winner = 1'b0;
        winner      = '0;
        idx         = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!have_winner && bus.req_valid_i[idx]) begin
                have_winner = 1'b1;
                winner      = idx;
            end
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
        end
    end

    // Accept when the register is free or drains this cycle; never during
    // flush or reset.
    always_comb begin
        can_accept = !reset && !bus.flush_i &&
                     ((state_q == RSP_EMPTY) || bus.rsp_ready_i);
        accept     = have_winner && can_accept;
    end

    // One-hot ready towards the winner only.
    always_comb begin
        bus.req_ready_o = '0;
        if (have_winner) begin
            bus.req_ready_o[winner] = can_accept;
        end
    end

    // ALU operand mux: the winner's fields even under backpressure so the
    // ALU inputs stay stable; all zero (ADD 0+0) when nobody is requesting.
    always_comb begin
        bus.alu_opr_a_o  = '0;
        bus.alu_opr_b_o  = '0;
        bus.alu_op_sel_o = '0;
        bus.alu_pc_o     = '0;
        if (have_winner) begin
            bus.alu_opr_a_o  = bus.req_opr_a_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            bus.alu_opr_b_o  = bus.req_opr_b_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            bus.alu_op_sel_o = bus.req_op_sel_i[int'(winner)*5 +: 5];
            bus.alu_pc_o     = bus.req_pc_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Next state of the response register, data fields and pointer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_res_d  = rsp_res_q;
        rsp_zero_d = rsp_zero_q;
        if (bus.flush_i) begin
            // Flush wins over a simultaneous drain; pointer and data hold.
            state_d = RSP_EMPTY;
        end else if (accept) begin
            // Covers both fill-from-empty and same-cycle drain+refill.
            state_d    = RSP_FULL;
            rsp_id_d   = winner;
            rsp_res_d  = bus.alu_res_i;
            rsp_zero_d = bus.alu_zero_i;
            ptr_d      = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end else if ((state_q == RSP_FULL) && bus.rsp_ready_i) begin
            state_d = RSP_EMPTY;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RSP_EMPTY;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_res_q  <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_res_q  <= rsp_res_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    // Response and debug outputs come straight from flops.
    always_comb begin
        bus.rsp_valid_o    = (state_q == RSP_FULL);
        bus.rsp_id_o       = rsp_id_q;
        bus.rsp_res_o      = rsp_res_q;
        bus.rsp_zero_o     = rsp_zero_q;
        bus.dbg_rsp_full_o = (state_q == RSP_FULL);
        bus.dbg_ptr_o      = ptr_q;
    end

    // Requester obligations and ready encoding.
    a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready_o));

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_rules
        a_valid_held: assert property (@(posedge clk) disable iff (reset)
            (bus.req_valid_i[k] && !bus.req_ready_o[k]) |=> bus.req_valid_i[k]);
        a_payload_stable: assert property (@(posedge clk) disable iff (reset)
            (bus.req_valid_i[k] && !bus.req_ready_o[k]) |=>
                ($stable(bus.req_opr_a_i[k*DATA_WIDTH +: DATA_WIDTH]) &&
                 $stable(bus.req_opr_b_i[k*DATA_WIDTH +: DATA_WIDTH]) &&
                 $stable(bus.req_op_sel_i[k*5 +: 5]) &&
                 $stable(bus.req_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH])));
    end
endmodule

// File: tb/tb_rv_alu_arbiter.sv
// Bench for rv_alu_arbiter: directed scenarios followed by random traffic,
// a reference model that predicts grants and responses, and a monitor that
// pops the expected queue whenever a response is consumed or flushed.
module tb_rv_alu_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int N  = 2;
  localparam int IW = $clog2(N);
  localparam int EW = IW + 1 + DW;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_EQL = 5'd2;
  localparam logic [4:0] OP_LT  = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_PC4 = 5'd7;

  logic clk;
  logic reset;

  rv_alu_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) bus ();

  rv_alu_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  logic [4:0]    tb_op [N];
  logic [DW-1:0] tb_a  [N];
  logic [DW-1:0] tb_b  [N];
  logic [AW-1:0] tb_pc [N];

  int model_ptr  = 0;
  bit model_full = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU behaviour: returns {zero, result} ----------------
  function automatic logic [DW:0] alu_ref(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [AW-1:0] pc);
    logic [DW-1:0] res;
    logic          zero;
    res  = '0;
    zero = 1'b0;
    case (op)
      OP_ADD: res = a + b;
      OP_SUB: res = a - b;
      OP_EQL: zero = (a == b);
      OP_LT:  zero = ($signed(a) < $signed(b));
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_PC4: res = DW'(pc + AW'(4));
      default: res = a + b;
    endcase
    return {zero, res};
  endfunction

  // combinational ALU stub fed by the arbiter
  always_comb begin
    {bus.alu_zero_i, bus.alu_res_i} = alu_ref(bus.alu_op_sel_o, bus.alu_opr_a_o,
                                              bus.alu_opr_b_o, bus.alu_pc_o);
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [4:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [AW-1:0] pc);
    tb_op[k] = op;
    tb_a[k]  = a;
    tb_b[k]  = b;
    tb_pc[k] = pc;
    bus.req_op_sel_i[k*5 +: 5]  = op;
    bus.req_opr_a_i[k*DW +: DW] = a;
    bus.req_opr_b_i[k*DW +: DW] = b;
    bus.req_pc_i[k*AW +: AW]    = pc;
    bus.req_valid_i[k]          = 1'b1;
  endtask

  // called at a negedge: note accepted requests, move past the edge, retire them
  task automatic advance();
    logic [N-1:0] acc;
    acc = bus.req_ready_o & bus.req_valid_i;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) bus.req_valid_i[k] = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.req_valid_i == '0 && !bus.rsp_valid_o) done = 1;
      else advance();
    end
    check(name, done, 1);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  always @(negedge clk) begin : ref_model
    int w;
    bit can;
    logic [N-1:0] exp_rdy;
    if (reset) begin
      check("ready_in_reset", bus.req_ready_o, '0);
      model_ptr  = 0;
      model_full = 0;
      exp_q.delete();
    end else begin
      check("rsp_valid", bus.rsp_valid_o, model_full);
      check("ptr", bus.dbg_ptr_o, model_ptr);
      w = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (model_ptr + i) % N;
        if (w < 0 && bus.req_valid_i[k]) w = k;
      end
      can = !bus.flush_i && (!model_full || bus.rsp_ready_i);
      exp_rdy = '0;
      if (w >= 0 && can) exp_rdy[w] = 1'b1;
      check("req_ready", bus.req_ready_o, exp_rdy);
      if (w >= 0) begin
        check("alu_op", bus.alu_op_sel_o, tb_op[w]);
        check("alu_a", bus.alu_opr_a_o, tb_a[w]);
        check("alu_b", bus.alu_opr_b_o, tb_b[w]);
        check("alu_pc", bus.alu_pc_o, tb_pc[w]);
      end else begin
        check("alu_idle", {bus.alu_op_sel_o, bus.alu_opr_a_o, bus.alu_opr_b_o}, '0);
      end
      if (bus.flush_i) begin
        model_full = 0;
      end else if (w >= 0 && can) begin
        exp_q.push_back({IW'(w), alu_ref(tb_op[w], tb_a[w], tb_b[w], tb_pc[w])});
        model_full = 1;
        model_ptr  = (w + 1) % N;
      end else if (model_full && bus.rsp_ready_i) begin
        model_full = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (!reset && bus.rsp_valid_o && (bus.flush_i || bus.rsp_ready_i)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=id%0d res=0x%0h required=no_response t=%0t",
                 bus.rsp_id_o, bus.rsp_res_o, $time);
      end else begin
        e = exp_q.pop_front();
        if (!bus.flush_i) check("rsp", {bus.rsp_id_o, bus.rsp_zero_o, bus.rsp_res_o}, e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.rsp_ready_i  = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_opr_a_i  = '0;
    bus.req_opr_b_i  = '0;
    bus.req_op_sel_i = '0;
    bus.req_pc_i     = '0;
    for (int k = 0; k < N; k++) begin
      tb_op[k] = '0; tb_a[k] = '0; tb_b[k] = '0; tb_pc[k] = '0;
    end

    // reset then idle
    set_req(0, OP_SUB, 64'd3, 64'd1, 64'h0);
    @(negedge clk);
    check("reset_ready", bus.req_ready_o, '0);
    check("reset_rsp", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_zero_o, bus.rsp_res_o}, '0);
    @(posedge clk);
    #1 bus.req_valid_i = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", bus.rsp_valid_o, 0);
      check("idle_opsel", bus.alu_op_sel_o, 0);
      advance();
    end

    // single op from requester 1
    bus.rsp_ready_i = 1'b1;
    set_req(1, OP_ADD, 64'd5, 64'd7, 64'h100);
    @(negedge clk);
    check("single_grant", bus.req_ready_o, 2'b10);
    advance();
    @(negedge clk);
    check("single_valid", bus.rsp_valid_o, 1);
    check("single_res", bus.rsp_res_o, 12);
    check("single_id", bus.rsp_id_o, 1);
    check("single_ptr", bus.dbg_ptr_o, 0);
    advance();
    drain("single_drain");

    // contention: both valid for 4 cycles
    pulse_reset();
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.req_valid_i[k]) set_req(k, OP_ADD, DW'(i * 10 + k), 64'd1, 64'h200);
      end
      @(negedge clk);
      if (i > 0) check("cont_id", bus.rsp_id_o, (i - 1) % 2);
      check("cont_grant", bus.req_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      advance();
    end
    @(negedge clk);
    check("cont_id", bus.rsp_id_o, 1);
    advance();
    drain("cont_drain");

    // backpressure with a full register
    pulse_reset();
    bus.rsp_ready_i = 1'b0;
    set_req(1, OP_EQL, 64'd3, 64'd3, 64'h300);
    @(negedge clk);
    advance();
    set_req(0, OP_SUB, 64'd9, 64'd4, 64'h304);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", bus.req_ready_o, '0);
      check("bp_hold", {bus.rsp_valid_o, bus.rsp_zero_o, bus.rsp_id_o}, {1'b1, 1'b1, 1'b1});
      advance();
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("bp_refill_grant", bus.req_ready_o, 2'b01);
    advance();
    @(negedge clk);
    check("bp_res", bus.rsp_res_o, 5);
    check("bp_id", bus.rsp_id_o, 0);
    check("bp_zero", bus.rsp_zero_o, 0);
    advance();
    drain("bp_drain");

    // flush with a full register and a waiting request
    pulse_reset();
    bus.rsp_ready_i = 1'b0;
    set_req(0, OP_ADD, 64'd1, 64'd2, 64'h400);
    @(negedge clk);
    advance();
    set_req(1, OP_OR, 64'd6, 64'd3, 64'h404);
    bus.flush_i     = 1'b1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("flush_ready", bus.req_ready_o, '0);
    advance();
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_valid", bus.rsp_valid_o, 0);
    check("flush_ptr", bus.dbg_ptr_o, 1);
    advance();
    drain("flush_drain");

    // asynchronous reset while full
    pulse_reset();
    bus.rsp_ready_i = 1'b0;
    set_req(0, OP_XOR, 64'hff, 64'h0f, 64'h500);
    @(negedge clk);
    advance();
    #1 check("async_pre_valid", bus.rsp_valid_o, 1);
    reset = 1'b1;
    #1 check("async_valid", bus.rsp_valid_o, 0);
    check("async_ptr", bus.dbg_ptr_o, 0);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    set_req(0, OP_PC4, 64'd0, 64'd0, 64'h600);
    set_req(1, OP_AND, 64'hf0, 64'h3c, 64'h604);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("async_grant", bus.req_ready_o, 2'b01);
    advance();
    @(negedge clk);
    check("async_id", bus.rsp_id_o, 0);
    advance();
    drain("async_drain");

    // random traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      advance();
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) begin
        if (!bus.req_valid_i[k] && ($urandom_range(0, 1) == 1)) begin
          if ($urandom_range(0, 1) == 1)
            set_req(k, 5'($urandom_range(0, 7)), DW'($urandom_range(0, 3)),
                    DW'($urandom_range(0, 3)), {$urandom, $urandom});
          else
            set_req(k, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom});
        end
      end
    end
    drain("rand_drain");
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
